// File: rtl/hc_sr04_distance_proc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hc_sr04_distance_proc
// Purpose  : Converts a captured HC-SR04 echo width (clock cycles) into cm
//            with a 22-iteration restoring divider. The result is range
//            checked and clamped, optionally smoothed by a 4-sample moving
//            average, and delivered through a valid/ready handshake.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            sensor_ready_i   - rising edge marks a finished measurement
//            distance_raw_i   - echo width in cycles (22 bits)
//            dist_cm_o        - distance in cm (16 bits)
//            out_of_range_o   - dist_cm_o is clamped (0 or MAX_CM)
//            dist_valid_o     - result available, held until accepted
//            dist_ready_i     - consumer accepts the result
//            overrun_o        - 1-cycle pulse when a measurement is dropped
// Options  : DIST_AVG_EN      - define to enable the 4-sample moving average
// Revision : 1.0 - initial release
// ============================================================================
module hc_sr04_distance_proc #(
  parameter logic [15:0] CYCLES_PER_CM = 16'd696,
  parameter logic [15:0] MAX_CM        = 16'd400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sensor_ready_i,
  input  logic [21:0] distance_raw_i,
  output logic [15:0] dist_cm_o,
  output logic        out_of_range_o,
  output logic        dist_valid_o,
  input  logic        dist_ready_i,
  output logic        overrun_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FINISH = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t      state_q;
  logic        sensor_ready_q;
  // Remainder is always below the 16-bit divisor, so 16 bits are kept; the
  // 17-bit partial remainder exists only as the trial value below.
  logic [15:0] rem_q;
  logic [15:0] rem_d;
  // Dividend shifts out MSB-first while quotient bits shift in at the LSB,
  // so after 22 iterations this register holds the full 22-bit quotient.
  logic [21:0] dvd_q;
  logic [21:0] dvd_d;
  logic [4:0]  cnt_q;
  logic [16:0] trial;
  logic        take;
  logic        capture;
  logic        in_range;
  logic [15:0] filt_cm;

  assign capture  = sensor_ready_i & ~sensor_ready_q;
  // Full 22-bit quotient is compared before any truncation.
  assign in_range = (dvd_q != 22'd0) && (dvd_q <= {6'd0, MAX_CM});

  always_comb begin
    trial = {rem_q, dvd_q[21]};
    take  = (trial >= {1'b0, CYCLES_PER_CM});
    rem_d = take ? 16'(trial - {1'b0, CYCLES_PER_CM}) : trial[15:0];
    dvd_d = {dvd_q[20:0], take};
  end

`ifdef DIST_AVG_EN
  logic [15:0] h0_q, h1_q, h2_q, h3_q;
  logic        primed_q;
  logic [17:0] sum;

  // Output is computed from the history as it will look after the new
  // sample is shifted in; an unprimed history behaves as four copies of q.
  always_comb begin
    if (primed_q) begin
      sum = {2'b00, dvd_q[15:0]} + {2'b00, h0_q} + {2'b00, h1_q} + {2'b00, h2_q};
    end else begin
      sum = {dvd_q[15:0], 2'b00};
    end
  end

  assign filt_cm = 16'((sum + 18'd2) >> 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      h0_q     <= 16'd0;
      h1_q     <= 16'd0;
      h2_q     <= 16'd0;
      h3_q     <= 16'd0;
      primed_q <= 1'b0;
    end else if (state_q == FINISH && in_range) begin
      primed_q <= 1'b1;
      if (primed_q) begin
        h0_q <= dvd_q[15:0];
        h1_q <= h0_q;
        h2_q <= h1_q;
        h3_q <= h2_q;
      end else begin
        h0_q <= dvd_q[15:0];
        h1_q <= dvd_q[15:0];
        h2_q <= dvd_q[15:0];
        h3_q <= dvd_q[15:0];
      end
    end
  end
`else
  assign filt_cm = dvd_q[15:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      // Reset high so a sensor already idling at ready=1 is not an edge.
      sensor_ready_q <= 1'b1;
      rem_q          <= 16'd0;
      dvd_q          <= 22'd0;
      cnt_q          <= 5'd0;
      dist_cm_o      <= 16'd0;
      out_of_range_o <= 1'b0;
      dist_valid_o   <= 1'b0;
      overrun_o      <= 1'b0;
    end else begin
      sensor_ready_q <= sensor_ready_i;
      // Any capture outside IDLE (including the accepting HOLD cycle) is lost.
      overrun_o      <= capture && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (capture) begin
            dvd_q   <= distance_raw_i;
            rem_q   <= 16'd0;
            cnt_q   <= 5'd0;
            state_q <= DIVIDE;
          end
        end
        DIVIDE: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd21) begin
            state_q <= FINISH;
          end
        end
        FINISH: begin
          if (dvd_q == 22'd0) begin
            dist_cm_o      <= 16'd0;
            out_of_range_o <= 1'b1;
          end else if (!in_range) begin
            dist_cm_o      <= MAX_CM;
            out_of_range_o <= 1'b1;
          end else begin
            dist_cm_o      <= filt_cm;
            out_of_range_o <= 1'b0;
          end
          dist_valid_o <= 1'b1;
          state_q      <= HOLD;
        end
        HOLD: begin
          if (dist_ready_i) begin
            dist_valid_o <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
